// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types, constants and pulse-width helper for the servo PWM sequencer
//
// Purpose: FSM state type, level range, default timing constants and the
// pulse-width calculation used by servo_pwm_sequencer.
// Ports: none (package).
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } servo_state_t;

  localparam int LEVEL_W   = 3;
  localparam int LEVEL_MAX = 7;

  // Frame tick counter and pulse width share this width.
  localparam int CNT_W = 12;

  localparam int DEF_TICK_DIV       = 500;
  localparam int DEF_FRAME_TICKS    = 2000;
  localparam int DEF_MIN_TICKS      = 100;
  localparam int DEF_STEP_TICKS     = 14;
  localparam int DEF_DEBOUNCE_TICKS = 1000;
  localparam int DEF_SWEEP_FRAMES   = 25;

  // Pulse width in ticks for a given level, in 12-bit unsigned arithmetic.
  function automatic logic [CNT_W-1:0] pulse_width(input logic [LEVEL_W-1:0] lvl,
                                                   input int min_ticks,
                                                   input int step_ticks);
    return CNT_W'(min_ticks) + CNT_W'(lvl) * CNT_W'(step_ticks);
  endfunction

endpackage

// File: rtl/servo_pwm_sequencer_btn_debounce.sv
// rtl/servo_pwm_sequencer_btn_debounce.sv - synchroniser, tick-based debouncer and press detector for one button
//
// Purpose: turns a raw asynchronous push-button into a single-cycle press event.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   tick        timing tick; debounce counting advances only on tick
//   btn         raw button input, asynchronous, active-high
//   press       one-cycle strobe on the rising edge of the debounced state
module btn_debounce
  import servo_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic press
);

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);

  logic [1:0]      sync_q;
  logic            btn_s;
  logic            state_q;
  logic            state_prev_q;
  logic [DB_W-1:0] db_cnt_q;

  assign btn_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  // Any cycle where the synced input agrees with the accepted state restarts
  // the count, so only an uninterrupted disagreement is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      state_q  <= 1'b0;
    end else if (btn_s == state_q) begin
      db_cnt_q <= '0;
    end else if (tick) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_TICKS - 1)) begin
        state_q  <= btn_s;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_prev_q <= 1'b0;
    end else begin
      state_prev_q <= state_q;
    end
  end

  assign press = state_q & ~state_prev_q;

endmodule

// File: rtl/servo_pwm_sequencer.sv
// rtl/servo_pwm_sequencer.sv - button-driven level select and 20 ms servo PWM frame sequencer
//
// Purpose: debounced up/down level selection (0..7) and a pulse/gap frame
// generator whose pulse width is set by the level latched at frame start.
// Optional feature macro: SERVO_SWEEP_EN (automatic ping-pong level sweep).
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   up, down     raw push-buttons, asynchronous, active-high
//   sweep_mode   auto-sweep request (only with SERVO_SWEEP_EN)
//   pwm_out      servo control pulse
//   level        currently selected level
//   frame_start  one-cycle strobe in the cycle the frame pulse begins
module servo_pwm_sequencer
  import servo_pkg::*;
#(
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int FRAME_TICKS    = DEF_FRAME_TICKS,
  parameter int MIN_TICKS      = DEF_MIN_TICKS,
  parameter int STEP_TICKS     = DEF_STEP_TICKS,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int SWEEP_FRAMES   = DEF_SWEEP_FRAMES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up,
  input  logic               down,
  input  logic               sweep_mode,
  output logic               pwm_out,
  output logic [LEVEL_W-1:0] level,
  output logic               frame_start
);

  if (MIN_TICKS + LEVEL_MAX * STEP_TICKS >= FRAME_TICKS) begin : g_width_check
    $error("longest pulse does not fit inside the frame");
  end

  localparam int              PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);

  logic [PRE_W-1:0]   pre_cnt_q;
  logic               tick;
  logic               up_ev;
  logic               down_ev;
  servo_state_t       state_q, state_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   width;
  logic [LEVEL_W-1:0] active_level_q;
  logic [LEVEL_W-1:0] level_d;
  logic               enter_pulse;

  assign tick = (pre_cnt_q == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else if (tick) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_q + 1'b1;
    end
  end

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_up_db (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(up), .press(up_ev)
  );

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_down_db (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(down), .press(down_ev)
  );

  assign width = pulse_width(active_level_q, MIN_TICKS, STEP_TICKS);

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    enter_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d     = PULSE;
          enter_pulse = 1'b1;
        end
      end
      PULSE: begin
        if (tick) begin
          fcnt_d = fcnt_q + 1'b1;
          if (fcnt_q == width - 1'b1) state_d = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          if (fcnt_q == FRAME_LAST) begin
            fcnt_d      = '0;
            state_d     = PULSE;
            enter_pulse = 1'b1;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Derived from state so an asserted reset drops the pin without a clock.
  assign pwm_out = (state_q == PULSE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      fcnt_q         <= '0;
      frame_start    <= 1'b0;
      active_level_q <= '0;
      level          <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      frame_start <= enter_pulse;
      level       <= level_d;
      // Uses level_d so a sweep step taken at frame start applies to this frame.
      if (enter_pulse) active_level_q <= level_d;
    end
  end

`ifdef SERVO_SWEEP_EN
  localparam int SW_W = (SWEEP_FRAMES > 1) ? $clog2(SWEEP_FRAMES) : 1;

  logic [SW_W-1:0] sweep_cnt_q;
  logic            sweep_dir_up_q;
  logic            sweep_step;
  logic            go_up;

  assign sweep_step = sweep_mode && enter_pulse && (sweep_cnt_q == SW_W'(SWEEP_FRAMES - 1));
  assign go_up      = (sweep_dir_up_q && level != LEVEL_W'(LEVEL_MAX)) ||
                      (!sweep_dir_up_q && level == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt_q    <= '0;
      sweep_dir_up_q <= 1'b1;
    end else begin
      if (!sweep_mode) begin
        sweep_cnt_q <= '0;
      end else if (enter_pulse) begin
        sweep_cnt_q <= sweep_step ? '0 : sweep_cnt_q + 1'b1;
      end
      if (sweep_step) sweep_dir_up_q <= go_up;
    end
  end

  always_comb begin
    level_d = level;
    if (sweep_mode) begin
      if (sweep_step) level_d = go_up ? level + 1'b1 : level - 1'b1;
    end else if (up_ev && !down_ev && level != LEVEL_W'(LEVEL_MAX)) begin
      level_d = level + 1'b1;
    end else if (down_ev && !up_ev && level != '0) begin
      level_d = level - 1'b1;
    end
  end
`else
  localparam int unused_sweep_frames = SWEEP_FRAMES;
  logic unused_sweep_mode;
  assign unused_sweep_mode = sweep_mode;

  always_comb begin
    level_d = level;
    if (up_ev && !down_ev && level != LEVEL_W'(LEVEL_MAX)) begin
      level_d = level + 1'b1;
    end else if (down_ev && !up_ev && level != '0) begin
      level_d = level - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_servo_pwm_sequencer.sv
// tb/tb_servo_pwm_sequencer.sv - scoreboard bench for servo_pwm_sequencer with a level/frame reference model
module tb_servo_pwm_sequencer;

  localparam int TICK_DIV       = 2;
  localparam int FRAME_TICKS    = 40;
  localparam int MIN_TICKS      = 5;
  localparam int STEP_TICKS     = 2;
  localparam int DEBOUNCE_TICKS = 3;
  localparam int SWEEP_FRAMES   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       sweep_mode = 1'b0;
  logic       pwm_out;
  logic [2:0] level;
  logic       frame_start;

  always #5 clk = ~clk;

  servo_pwm_sequencer #(
    .TICK_DIV(TICK_DIV), .FRAME_TICKS(FRAME_TICKS), .MIN_TICKS(MIN_TICKS),
    .STEP_TICKS(STEP_TICKS), .DEBOUNCE_TICKS(DEBOUNCE_TICKS), .SWEEP_FRAMES(SWEEP_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .up(up), .down(down), .sweep_mode(sweep_mode),
    .pwm_out(pwm_out), .level(level), .frame_start(frame_start)
  );

  typedef struct {
    int high;
    int period;
    int lvl;
  } frame_exp_t;

  frame_exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int model_level = 0;
  bit mon_en = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int exp_high(input int l);
    return (MIN_TICKS + l * STEP_TICKS) * TICK_DIV;
  endfunction

  // Monitor: measures each frame from one frame_start to the next.
  bit in_frame = 0;
  int hi_cnt = 0;
  int per_cnt = 0;
  int lvl_at = 0;

  always @(negedge clk) begin : monitor
    frame_exp_t e;
    if (!mon_en) begin
      in_frame = 0;
    end else begin
      if (frame_start) begin
        if (in_frame) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("frame_high_cycles", hi_cnt, e.high);
            check("frame_period", per_cnt, e.period);
            check("frame_level", lvl_at, e.lvl);
          end
        end
        in_frame = 1;
        hi_cnt   = 0;
        per_cnt  = 0;
        lvl_at   = int'(level);
      end
      if (in_frame) begin
        per_cnt++;
        if (pwm_out) hi_cnt++;
      end
    end
  end

  task automatic wait_frame();
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (frame_start) seen = 1;
    end
    if (!seen) check("frame_start_timeout", 0, 1);
  endtask

  // 0 idle, 1 up press, 2 down press, 3 up bounce, 4 up+down together, 5 down bounce
  task automatic do_action(input int a);
    int hold = $urandom_range(12, 40);
    case (a)
      1: begin
        up = 1'b1; repeat (hold) @(negedge clk); up = 1'b0;
        model_level = (model_level < 7) ? model_level + 1 : 7;
      end
      2: begin
        down = 1'b1; repeat (hold) @(negedge clk); down = 1'b0;
        model_level = (model_level > 0) ? model_level - 1 : 0;
      end
      3: begin
        up = 1'b1; repeat (3) @(negedge clk); up = 1'b0; @(negedge clk);
        up = 1'b1; repeat (3) @(negedge clk); up = 1'b0;
      end
      4: begin
        up = 1'b1; down = 1'b1; repeat (hold) @(negedge clk); up = 1'b0; down = 1'b0;
      end
      5: begin
        down = 1'b1; repeat (4) @(negedge clk); down = 1'b0; @(negedge clk);
        down = 1'b1; repeat (2) @(negedge clk); down = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic run_frame(input int a);
    frame_exp_t e;
    wait_frame();
    e.high   = exp_high(model_level);
    e.period = FRAME_TICKS * TICK_DIV;
    e.lvl    = model_level;
    exp_q.push_back(e);
    do_action(a);
  endtask

  initial begin
    int n;
    int h;
    bit done;
    repeat (3) @(negedge clk);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_level", int'(level), 0);
    check("reset_frame_start", int'(frame_start), 0);
    rst_n  = 1'b1;
    mon_en = 1;

    repeat (2) run_frame(0);
    repeat (3) run_frame(1);
    run_frame(0);
    repeat (10) run_frame(1);
    run_frame(0);
    repeat (9) run_frame(2);
    run_frame(0);
    run_frame(3);
    run_frame(1);
    run_frame(1);
    run_frame(4);
    run_frame(5);
    run_frame(0);
    repeat (30) run_frame($urandom_range(0, 5));
    run_frame(0);

    wait_frame();
    @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 0);
    mon_en = 0;

    // Asynchronous reset in the middle of a pulse.
    do_action(1);
    wait_frame();
    do_action(1);
    wait_frame();
    check("pwm_before_reset", int'(pwm_out), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pwm_out", int'(pwm_out), 0);
    check("async_reset_level", int'(level), 0);
    check("async_reset_frame_start", int'(frame_start), 0);
    model_level = 0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      n++;
      if (frame_start) done = 1;
    end
    check("first_frame_latency", n, TICK_DIV);
    check("post_reset_level", int'(level), model_level);
    h = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (pwm_out) h++;
      else done = 1;
      if (!done) @(negedge clk);
    end
    check("post_reset_high_cycles", h, exp_high(model_level));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
